ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 131 +++++++++++++
 tb/tb_ps2_host_tx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Clock inhibit, request-to-send, 11-edge shift-out, ACK check and timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2k_clk,
    input  logic       ps2k_data,
    output logic       ps2k_clk_oe,
    output logic       ps2k_data_oe
);
    localparam int MAXC = INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] IDLE = 3'd0, INHIBIT = 3'd1, REQ = 3'd2, DATA = 3'd3,
                           PARITY = 3'd4, STOP = 3'd5, ACK = 3'd6, WAIT_IDLE = 3'd7;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d, dat_q, dat_d, ack_q, ack_d;
    logic          done_q, done_d, err_q, err_d;
    logic [1:0]    cs_q, ds_q;
    logic          cprev_q;
    logic          fall, timeout, inh_last;
    assign fall     = cprev_q & ~cs_q[1];
    assign timeout  = state_q >= REQ && cnt_q == TO_LAST;
    assign inh_last = state_q == INHIBIT && cnt_q == INH_LAST;
    assign busy         = state_q != IDLE;
    assign done         = done_q;
    assign error        = err_q;
    assign ps2k_clk_oe  = state_q == INHIBIT;
    // start bit goes out in the final inhibit cycle, ahead of the registered data driver
    assign ps2k_data_oe = dat_q | inh_last;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        dat_d   = dat_q;
        ack_d   = ack_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (timeout) begin
            state_d = IDLE;
            dat_d   = 1'b0;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    bit_d = '0;
                    if (tx_start) begin
                        sh_d    = tx_data;
                        par_d   = ~^tx_data;
                        state_d = INHIBIT;
                    end
                end
                INHIBIT: if (inh_last) begin
                    state_d = REQ;
                    cnt_d   = '0;
                    dat_d   = 1'b1;
                end
                REQ, DATA, PARITY, STOP: if (fall && bit_q != 4'd11) begin
                    bit_d = bit_q + 4'd1;
                    if (state_q == STOP) begin
                        ack_d   = ds_q[1];
                        state_d = ACK;
                    end else if (state_q == PARITY) begin
                        dat_d   = 1'b0;
                        state_d = STOP;
                    end else if (bit_q == 4'd8) begin
                        dat_d   = ~par_q;
                        state_d = PARITY;
                    end else begin
                        dat_d   = ~sh_q[0];
                        sh_d    = sh_q >> 1;
                        state_d = DATA;
                    end
                end
                ACK: begin
                    state_d = ack_q ? IDLE : WAIT_IDLE;
                    err_d   = ack_q;
                end
                WAIT_IDLE: if (cs_q[1] && ds_q[1]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            dat_q   <= 1'b0;
            ack_q   <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cs_q    <= 2'b11;
            ds_q    <= 2'b11;
            cprev_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cs_q    <= {cs_q[0], ps2k_clk};
            ds_q    <= {ds_q[0], ps2k_data};
            cprev_q <= cs_q[1];
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed table-driven bench with a behavioural PS/2 device on open-drain lines.
module tb_ps2_host_tx;
    localparam int INH = 20;
    localparam int TO = 400;
    typedef struct {
        logic [7:0] d;
        logic       ack;
        logic       par;
        int         exp_done;
        int         exp_err;
    } vec_t;
    vec_t v[6];
    logic clk = 0, reset = 0, tx_start = 0, dev_clk = 1, dev_data = 1;
    logic [7:0] tx_data = '0;
    logic busy, done, error, ps2k_clk_oe, ps2k_data_oe, ps2k_clk, ps2k_data;
    int checks = 0, errors = 0, n_done = 0, n_err = 0, n_both = 0;
    assign ps2k_clk  = dev_clk & ~ps2k_clk_oe;
    assign ps2k_data = dev_data & ~ps2k_data_oe;
    always #5 clk = ~clk;
    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
        .busy(busy), .done(done), .error(error),
        .ps2k_clk(ps2k_clk), .ps2k_data(ps2k_data),
        .ps2k_clk_oe(ps2k_clk_oe), .ps2k_data_oe(ps2k_data_oe)
    );
    always @(negedge clk) begin
        if (done) n_done += 1;
        if (error) n_err += 1;
        if (done && error) n_both += 1;
    end
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask
    task automatic pulse_start(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1;
        @(negedge clk);
        tx_start = 0;
    endtask
    task automatic wait_inhibit(output int inh, output int nd, output logic dlast);
        inh = 0; nd = 0; dlast = 0;
        while (ps2k_clk_oe && inh < INH + 50) begin
            inh++;
            if (ps2k_data_oe) nd++;
            dlast = ps2k_data_oe;
            @(negedge clk);
        end
    endtask
    task automatic device(input int rst_at, input logic ack_low, output logic [10:0] got);
        got = '0;
        repeat (3) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && ack_low) begin
                dev_data = 0;
                repeat (2) @(negedge clk);
            end
            dev_clk = 0;
            if (k == rst_at) begin
                repeat (4) @(negedge clk);
                reset = 0;
                @(negedge clk);
                chk("reset_mid_outputs", {busy, done, error, ps2k_clk_oe, ps2k_data_oe}, 0);
                dev_clk = 1; dev_data = 1;
                @(negedge clk);
                reset = 1;
                @(negedge clk);
                return;
            end
            repeat (8) @(negedge clk);
            got[k-1] = ps2k_data;
            dev_clk = 1;
            repeat (8) @(negedge clk);
        end
        dev_data = 1;
    endtask
    task automatic finish_wait();
        int k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("busy_drop", busy, 0);
        repeat (2) @(negedge clk);
    endtask
    initial begin
        int inh, nd, d0, e0, k, viol;
        logic dlast;
        logic [10:0] got;
        v[0] = '{8'hED, 1'b1, 1'b1, 1, 0};
        v[1] = '{8'hF4, 1'b1, 1'b0, 1, 0};
        v[2] = '{8'hFF, 1'b1, 1'b1, 1, 0};
        v[3] = '{8'h00, 1'b1, 1'b1, 1, 0};
        v[4] = '{8'h01, 1'b1, 1'b0, 1, 0};
        v[5] = '{8'hED, 1'b0, 1'b1, 0, 1};
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, error, ps2k_clk_oe, ps2k_data_oe}, 0);
        // start request on the very first edge out of reset
        reset = 1;
        d0 = n_done;
        pulse_start(8'hED);
        chk("first_start_busy", busy, 1);
        wait_inhibit(inh, nd, dlast);
        device(0, 1'b1, got);
        chk("first_byte", got[7:0], 8'hED);
        finish_wait();
        chk("first_done", n_done - d0, 1);
        viol = 0;
        for (int i = 0; i < 11; i++) begin
            dev_data = i[0];
            dev_clk = 0;
            repeat (4) begin @(negedge clk); if ({busy, done, error, ps2k_clk_oe, ps2k_data_oe} != 0) viol++; end
            dev_clk = 1;
            repeat (4) begin @(negedge clk); if ({busy, done, error, ps2k_clk_oe, ps2k_data_oe} != 0) viol++; end
        end
        dev_data = 1;
        repeat (6) @(negedge clk);
        chk("idle_traffic", viol, 0);
        foreach (v[i]) begin
            d0 = n_done; e0 = n_err;
            pulse_start(v[i].d);
            wait_inhibit(inh, nd, dlast);
            chk("inhibit_len", inh, INH);
            chk("start_bit_last", dlast, 1);
            chk("start_bit_once", nd, 1);
            chk("req_data_low", ps2k_data_oe, 1);
            device(0, v[i].ack, got);
            chk("byte", got[7:0], v[i].d);
            chk("parity", got[8], v[i].par);
            chk("stop", got[9], 1);
            finish_wait();
            chk("done_count", n_done - d0, v[i].exp_done);
            chk("error_count", n_err - e0, v[i].exp_err);
            chk("lines_released", {ps2k_clk_oe, ps2k_data_oe}, 0);
        end
        d0 = n_done; e0 = n_err;
        pulse_start(8'h55);
        wait_inhibit(inh, nd, dlast);
        k = 0;
        while (!error && k < 2 * TO) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_cycles", k, TO);
        chk("timeout_lines", {ps2k_clk_oe, ps2k_data_oe}, 0);
        chk("timeout_busy", busy, 0);
        repeat (2) @(negedge clk);
        chk("timeout_done", n_done - d0, 0);
        chk("timeout_error", n_err - e0, 1);
        // a second request mid-transfer must not disturb the latched byte
        d0 = n_done;
        pulse_start(8'hED);
        tx_data = 8'hFF;
        tx_start = 1;
        @(negedge clk);
        tx_start = 0;
        wait_inhibit(inh, nd, dlast);
        device(0, 1'b1, got);
        chk("busy_ignore_byte", got[7:0], 8'hED);
        chk("busy_ignore_parity", got[8], 1);
        finish_wait();
        chk("busy_ignore_done", n_done - d0, 1);
        d0 = n_done; e0 = n_err;
        pulse_start(8'hFF);
        wait_inhibit(inh, nd, dlast);
        device(5, 1'b1, got);
        repeat (4) @(negedge clk);
        chk("abort_no_pulses", (n_done - d0) + (n_err - e0), 0);
        pulse_start(8'hFF);
        wait_inhibit(inh, nd, dlast);
        chk("after_reset_inhibit", inh, INH);
        device(0, 1'b1, got);
        chk("after_reset_byte", got[7:0], 8'hFF);
        chk("after_reset_parity", got[8], 1);
        finish_wait();
        chk("after_reset_done", n_done - d0, 1);
        chk("done_error_overlap", n_both, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
